// File: rtl/cpu_pkg.sv
// Shared definitions for the command fetch path: FSM state encoding, the NOP
// command word and the default command/address widths.
package cpu_pkg;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PUSH  = 3'd3,
    ST_PAD   = 3'd4
  } state_t;

  localparam logic [DATA_W-1:0] CMD_NOP = '0;

endpackage

// File: rtl/command_fetch.sv
// Command fetch: walks pc through program memory and pushes each word into the command buffer.
// 3 cycles per word (FETCH, LOAD, PUSH); first comm_write 3 cycles after start.
// PUSH retries while pause_READ is set; CMD_PAIR_ALIGN_EN adds NOP padding so accepted words stay paired.
module command_fetch #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              halt,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] command_out,
  output logic              comm_write,
  input  logic              pause_READ,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  words_sent
);
  import cpu_pkg::*;

  state_t            state;
  logic              accepted;
  logic [ADDR_W-1:0] pc_inc;
  logic [CNT_W-1:0]  cnt_sat;

  assign pc_inc  = pc + ADDR_W'(1);
  assign cnt_sat = (&words_sent) ? words_sent : words_sent + CNT_W'(1);

`ifdef CMD_PAIR_ALIGN_EN
  logic parity;
  logic parity_next;
  logic pad_to_idle;

  assign accepted    = ((state == ST_PUSH) || (state == ST_PAD)) && !pause_READ;
  assign parity_next = parity ^ accepted;
`else
  assign accepted = (state == ST_PUSH) && !pause_READ;
`endif

  // pause_READ always describes the write attempt of the cycle just ending,
  // so a PUSH/PAD word is accepted exactly when it is low at this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      mem_addr    <= '0;
      command_out <= '0;
      words_sent  <= '0;
      mem_rd      <= 1'b0;
      comm_write  <= 1'b0;
      busy        <= 1'b0;
`ifdef CMD_PAIR_ALIGN_EN
      parity      <= 1'b0;
      pad_to_idle <= 1'b0;
`endif
    end else begin
      mem_rd     <= 1'b0;
      comm_write <= 1'b0;
      if (accepted) words_sent <= cnt_sat;
`ifdef CMD_PAIR_ALIGN_EN
      parity <= parity_next;
`endif

      if (state == ST_IDLE) begin
        if (start) begin
          pc       <= start_addr;
          mem_addr <= start_addr;
          mem_rd   <= 1'b1;
          busy     <= 1'b1;
          state    <= ST_FETCH;
        end
`ifdef CMD_PAIR_ALIGN_EN
      end else if (state == ST_PAD) begin
        // The pad word always completes; halt/jump only choose where to go afterwards.
        if (halt) pad_to_idle <= 1'b1;
        else if (jump_valid) pc <= jump_addr;
        if (pause_READ) begin
          comm_write <= 1'b1;
        end else if (pad_to_idle || halt) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          mem_addr <= jump_valid ? jump_addr : pc;
          mem_rd   <= 1'b1;
          state    <= ST_FETCH;
        end
      end else if (halt) begin
        if (accepted) pc <= pc_inc;
        if (parity_next) begin
          state       <= ST_PAD;
          pad_to_idle <= 1'b1;
          command_out <= DATA_W'(CMD_NOP);
          comm_write  <= 1'b1;
        end else begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      end else if (jump_valid) begin
        pc <= jump_addr;
        if (parity_next) begin
          state       <= ST_PAD;
          pad_to_idle <= 1'b0;
          command_out <= DATA_W'(CMD_NOP);
          comm_write  <= 1'b1;
        end else begin
          mem_addr <= jump_addr;
          mem_rd   <= 1'b1;
          state    <= ST_FETCH;
        end
`else
      end else if (halt) begin
        if (accepted) pc <= pc_inc;
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (jump_valid) begin
        pc       <= jump_addr;
        mem_addr <= jump_addr;
        mem_rd   <= 1'b1;
        state    <= ST_FETCH;
`endif
      end else begin
        case (state)
          ST_FETCH: state <= ST_LOAD;
          ST_LOAD: begin
            command_out <= mem_data;
            comm_write  <= 1'b1;
            state       <= ST_PUSH;
          end
          ST_PUSH: begin
            if (pause_READ) begin
              comm_write <= 1'b1;
            end else begin
              pc       <= pc_inc;
              mem_addr <= pc_inc;
              mem_rd   <= 1'b1;
              state    <= ST_FETCH;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_command_fetch.sv
// Bench for command_fetch: memory + command buffer models, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_command_fetch;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 6;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef CMD_PAIR_ALIGN_EN
  localparam bit PAIR = 1'b1;
  localparam int EXP6_CNT = 4;
  localparam logic [DATA_W-1:0] EXP6_W3 = 14'h0000;
`else
  localparam bit PAIR = 1'b0;
  localparam int EXP6_CNT = 3;
  localparam logic [DATA_W-1:0] EXP6_W3 = 14'h142B;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b0, start = 1'b0, halt = 1'b0, jump_valid = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0, jump_addr = '0;
  logic              mem_rd, comm_write, busy;
  logic [ADDR_W-1:0] mem_addr, pc;
  logic [DATA_W-1:0] mem_data = '0, command_out;
  logic              pause_READ = 1'b0;
  logic [CNT_W-1:0]  words_sent;

  command_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .halt(halt), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .command_out(command_out), .comm_write(comm_write), .pause_READ(pause_READ),
    .busy(busy), .pc(pc), .words_sent(words_sent)
  );

  logic [DATA_W-1:0] mem [256];
  int checks = 0, passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Program memory: data valid the cycle after mem_rd.
  initial forever begin
    @(posedge clk);
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  // Command buffer: samples on negedge, answers through pause_READ.
  bit                rand_pause = 0;
  logic [DATA_W-1:0] stall_word = '0;
  int                stall_req = 0, stall_used = 0, attempts = 0;
  bit                acc_flag = 0;
  logic [DATA_W-1:0] acc_q[$];
  logic [ADDR_W-1:0] fetch_q[$];

  // Reference model: "what is in flight and how far along it is".
  bit                seen_reset = 0, m_run = 0, m_par = 0, m_pad = 0, m_pad_idle = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  int                m_cnt = 0, m_phase = 0;
  bit                exp_cw, exp_rd;

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      seen_reset = 1; m_run = 0; m_addr = '0; m_cnt = 0;
      m_par = 0; m_pad = 0; m_pad_idle = 0; m_phase = 0;
    end else if (seen_reset) begin
      if (acc_flag) begin
        if (m_cnt < CMAX) m_cnt++;
        m_par = !m_par;
        if (!m_pad) m_addr = m_addr + 1'b1;
      end
      if (!m_run) begin
        if (start) begin m_run = 1; m_addr = start_addr; m_phase = 0; end
      end else if (m_pad) begin
        if (halt) m_pad_idle = 1;
        else if (jump_valid) m_addr = jump_addr;
        if (acc_flag) begin
          m_pad = 0;
          if (m_pad_idle) m_run = 0; else m_phase = 0;
        end
      end else if (halt) begin
        if (PAIR && m_par) begin m_pad = 1; m_pad_idle = 1; end
        else m_run = 0;
      end else if (jump_valid) begin
        m_addr = jump_addr;
        if (PAIR && m_par) begin m_pad = 1; m_pad_idle = 0; end
        else m_phase = 0;
      end else if (acc_flag) m_phase = 0;
      else if (m_phase < 2) m_phase++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (seen_reset) begin
      exp_cw = m_run && (m_pad || m_phase >= 2);
      exp_rd = m_run && !m_pad && m_phase == 0;
      check("busy", busy, m_run);
      check("comm_write", comm_write, exp_cw);
      check("mem_rd", mem_rd, exp_rd);
      if (exp_rd) check("mem_addr", mem_addr, m_addr);
      check("words_sent", words_sent, m_cnt);
      check("pc", pc, m_addr);
      if (exp_cw) check("command_out", command_out, m_pad ? '0 : mem[m_addr]);
    end
    if (mem_rd) fetch_q.push_back(mem_addr);
    acc_flag = 0;
    if (comm_write) begin
      attempts++;
      if (stall_used < stall_req && command_out == stall_word) begin
        pause_READ = 1'b1; stall_used++;
      end else if (rand_pause) pause_READ = ($urandom_range(0, 2) == 0);
      else pause_READ = 1'b0;
      if (!pause_READ) begin acc_flag = 1; acc_q.push_back(command_out); end
    end else if (rand_pause) pause_READ = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    reset = 1'b0; tick(); tick(); reset = 1'b1;
  endtask

  task automatic run_start(input logic [ADDR_W-1:0] a);
    start_addr = a; start = 1'b1; tick(); start = 1'b0;
    check("lat_fetch_rd", {mem_rd, mem_addr}, {1'b1, a});
    check("lat_c1", comm_write, 0);
    tick(); check("lat_c2", comm_write, 0);
    tick(); check("lat_c3", comm_write, 1);
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (words_sent != CNT_W'(n) && k < budget) begin tick(); k++; end
    check("wait_words", words_sent, n);
  endtask

  task automatic wait_fetch(input logic [ADDR_W-1:0] a, input int budget);
    int k = 0;
    while (!(mem_rd && mem_addr == a) && k < budget) begin tick(); k++; end
    check("wait_fetch", {mem_rd, mem_addr}, {1'b1, a});
  endtask

  task automatic stop();
    int k = 0;
    halt = 1'b1; tick(); halt = 1'b0;
    while (busy && k < 50) begin tick(); k++; end
    check("stop_idle", busy, 0);
  endtask

  int base, att0, fb, k;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {i[7:0], 6'h2B};
    mem[8'h10] = 14'h1A01; mem[8'h11] = 14'h1B02;
    mem[8'h12] = 14'h1C03; mem[8'h13] = 14'h1D04;
    mem[8'h40] = 14'h3C40;

    tick(); tick();
    check("rst_busy", busy, 0);       check("rst_cw", comm_write, 0);
    check("rst_rd", mem_rd, 0);       check("rst_addr", mem_addr, 0);
    check("rst_pc", pc, 0);           check("rst_cnt", words_sent, 0);
    check("rst_cmd", command_out, 0);
    reset = 1'b1;

    // Plain stream A,B,C,D from 0x10.
    base = acc_q.size(); att0 = attempts;
    run_start(8'h10);
    wait_words(4, 100);
    check("t1_pc", pc, 8'h14);
    check("t1_attempts", attempts - att0, 4);
    check("t1_A", acc_q[base], 14'h1A01); check("t1_B", acc_q[base+1], 14'h1B02);
    check("t1_C", acc_q[base+2], 14'h1C03); check("t1_D", acc_q[base+3], 14'h1D04);
    stop();

    // Five refusals on B.
    do_reset();
    base = acc_q.size(); att0 = attempts;
    stall_word = 14'h1B02; stall_req = stall_used + 5;
    run_start(8'h10);
    k = 0;
    while (!(comm_write && command_out == 14'h1B02) && k < 50) begin tick(); k++; end
    tick(); tick(); tick();
    check("t2_hold_cw", comm_write, 1);
    check("t2_hold_cmd", command_out, 14'h1B02);
    check("t2_hold_cnt", words_sent, 1);
    wait_words(4, 100);
    check("t2_attempts", attempts - att0, 9);
    check("t2_B", acc_q[base+1], 14'h1B02);
    check("t2_D", acc_q[base+3], 14'h1D04);
    stop();

    // Jump to 0x40 during LOAD of C.
    do_reset();
    base = acc_q.size();
    run_start(8'h10);
    wait_fetch(8'h12, 50);
    tick();
    jump_valid = 1'b1; jump_addr = 8'h40; tick(); jump_valid = 1'b0;
    check("t3_redirect", {mem_rd, mem_addr}, {1'b1, 8'h40});
    wait_words(3, 50);
    check("t3_third", acc_q[base+2], 14'h3C40);
    stop();

    // halt together with jump.
    do_reset();
    run_start(8'h20);
    wait_words(2, 50);
    halt = 1'b1; jump_valid = 1'b1; jump_addr = 8'h40; tick();
    halt = 1'b0; jump_valid = 1'b0;
    check("t4_busy", busy, 0); check("t4_cw", comm_write, 0); check("t4_rd", mem_rd, 0);
    att0 = attempts;
    repeat (10) tick();
    check("t4_no_write", attempts - att0, 0);
    check("t4_cnt", words_sent, 2);

    // pc wrap from 0xFF.
    do_reset();
    base = acc_q.size(); fb = fetch_q.size();
    run_start(8'hFF);
    wait_words(2, 50);
    check("t5_fetch0", fetch_q[fb], 8'hFF);
    check("t5_fetch1", fetch_q[fb+1], 8'h00);
    check("t5_pc", pc, 8'h01);
    check("t5_w1", acc_q[base+1], {8'h00, 6'h2B});
    stop();

    // Jump after three accepted words.
    do_reset();
    base = acc_q.size();
    run_start(8'h30);
    wait_words(3, 50);
    jump_valid = 1'b1; jump_addr = 8'h50; tick(); jump_valid = 1'b0;
    wait_fetch(8'h50, 20);
    check("t6_cnt", words_sent, EXP6_CNT);
    wait_words(EXP6_CNT + 1, 50);
    check("t6_w3", acc_q[base+3], EXP6_W3);
    check("t6_target", acc_q[base+EXP6_CNT], 14'h142B);

    // Reset while a push is pending.
    k = 0;
    while (!comm_write && k < 20) begin tick(); k++; end
    check("t7_in_push", comm_write, 1);
    reset = 1'b0; tick();
    check("t7_cw", comm_write, 0); check("t7_busy", busy, 0);
    reset = 1'b1;

    // Random traffic against the model.
    rand_pause = 1;
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 5) == 0);
      start_addr = 8'($urandom);
      halt       = ($urandom_range(0, 79) == 0);
      jump_valid = ($urandom_range(0, 14) == 0);
      jump_addr  = 8'($urandom);
      reset      = ($urandom_range(0, 699) != 0);
      tick();
    end
    start = 1'b0; halt = 1'b0; jump_valid = 1'b0; reset = 1'b1; rand_pause = 0;

    // Saturation of words_sent.
    do_reset();
    run_start(8'h00);
    wait_words(CMAX, 400);
    repeat (20) tick();
    check("sat_cnt", words_sent, 6'h3F);
    stop();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/command_fetch.md
Name: command_fetch

Overview:
- Producer side of the command buffer protocol.
- Walks a program counter through program memory and reads one DATA_W-bit command word per fetch.
- Pushes each word into the command buffer with comm_write/command_out and honours the buffer's pause_READ back-pressure.
- Sits between program memory and the command buffer, upstream of DECODE; supports start, halt and jump (redirect/flush).

Parameters:
- DATA_W, 14, command word width (matches the buffer's command_in).
- ADDR_W, 8, program memory address / PC width.
- CNT_W, 16, width of the words_sent counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- start  in  1  begin fetching at start_addr; honoured only in IDLE.
- start_addr  in  ADDR_W  first fetch address.
- halt  in  1  stop fetching and return to IDLE.
- jump_valid  in  1  one-cycle redirect request.
- jump_addr  in  ADDR_W  redirect target.
- mem_rd  out  1  program memory read strobe.
- mem_addr  out  ADDR_W  program memory address.
- mem_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd.
- command_out  out  DATA_W  word presented to the buffer.
- comm_write  out  1  write request to the buffer.
- pause_READ  in  1  buffer refusal flag from the previous write attempt.
- busy  out  1  high in every state except IDLE.
- pc  out  ADDR_W  address of the word currently in flight.
- words_sent  out  CNT_W  count of words accepted by the buffer.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - pc, mem_addr, command_out, words_sent = 0.
  - mem_rd, comm_write, busy = 0.
- FSM states: IDLE, FETCH, LOAD, PUSH (PAD only with the optional feature).
- IDLE: start=1 -> pc<=start_addr, go to FETCH. Any other input is ignored.
- FETCH: mem_rd=1, mem_addr=pc for one cycle; go to LOAD.
- LOAD: command_out<=mem_data; go to PUSH.
- PUSH:
  - comm_write=1; command_out is held stable.
  - The buffer samples on negedge, so at the next posedge pause_READ reflects this attempt.
  - pause_READ=1 -> stay in PUSH and retry with the same word, unbounded.
  - pause_READ=0 -> words_sent+1, pc<=pc+1, go to FETCH.
- pause_READ is evaluated only at the end of a PUSH cycle. Its value is don't-care in every other state, because the buffer only updates it on write attempts.
- Throughput: 3 cycles per word when not stalled. Latency from start to the first comm_write is 3 cycles.
- pc wraps modulo 2^ADDR_W; no end-of-program detection.
- jump_valid in FETCH/LOAD/PUSH:
  - The in-flight word is dropped; comm_write is deasserted next cycle.
  - pc<=jump_addr; go to FETCH.
  - A word whose PUSH is accepted in the same cycle as the jump still counts in words_sent.
- jump_valid in IDLE is ignored.
- halt in any non-IDLE state -> IDLE next cycle, comm_write=0.
- Priority: reset > halt > jump_valid > normal flow.
- reset mid-PUSH: comm_write drops on the same edge. The word may already have been taken on the preceding negedge; software must reset the buffer together with this block.
- words_sent saturates at all-ones.

Optional Feature:
- Macro: CMD_PAIR_ALIGN_EN.
- With the macro: DECODE consumes words in pairs, so a parity bit tracks accepted words.
  - On jump or halt with odd parity, enter PAD before FETCH/IDLE.
  - PAD pushes a NOP word (all zeros) with the same pause_READ retry rule.
  - The PAD word counts in words_sent.
  - A halt during PAD completes the PAD first.
- Without the macro: no PAD state; the parity bit is absent; jump and halt act immediately.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding constants (ST_IDLE, ST_FETCH, ST_LOAD, ST_PUSH, ST_PAD);
  - CMD_NOP (DATA_W'b0);
  - default widths DATA_W/ADDR_W.
- No sub-module required; an optional pc_counter sub-module (load/increment/wrap) is acceptable.

Test Plan:
- Reset, start_addr=8'h10, memory[16..19]=A,B,C,D, pause_READ=0 -> comm_write pulses every 3rd cycle with A,B,C,D; words_sent=4; pc=8'h14.
- pause_READ=1 for 5 PUSH attempts on word B -> comm_write held 5 extra cycles; command_out=B stable; words_sent advances only after release.
- jump_valid with jump_addr=8'h40 during LOAD of word C -> C never written; next comm_write carries mem[8'h40].
- halt asserted together with jump_valid -> IDLE next cycle; busy=0; no further comm_write.
- start_addr=8'hFF, 2 words -> second fetch at mem_addr=8'h00 (wrap).
- With CMD_PAIR_ALIGN_EN: 3 words accepted then a jump -> one NOP (0) pushed before the target fetch; words_sent=4. Without the macro: words_sent=3 and no NOP.
